// File: rtl/mult_div_seq_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
  typedef enum logic {OP_MULT, OP_DIV} op_e;

  // Width of the CALC iteration counter; never collapses to zero bits.
  function automatic int cnt_width(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

endpackage

// File: rtl/mult_div_seq_if.sv
// Control/operand/result bundle between the CPU control unit and mult_div_seq.
interface mult_div_seq_if #(parameter int WIDTH = 32);
  logic             mult_init;
  logic             div_init;
  logic             op_signed;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             mult_stop;
  logic             div_stop;
  logic             div_zero;
  logic             busy;

  modport master (
    output mult_init, div_init, op_signed, a_in, b_in,
    input  hi_out, lo_out, mult_stop, div_stop, div_zero, busy
  );

  modport slave (
    input  mult_init, div_init, op_signed, a_in, b_in,
    output hi_out, lo_out, mult_stop, div_stop, div_zero, busy
  );
endinterface

// File: rtl/mult_div_seq_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);
  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_diff;

  assign w_sh   = {i_rem, i_bit};
  assign w_diff = w_sh - {1'b0, i_div};
  // Remainder stays below the divisor, so a clear MSB of the difference means no borrow.
  assign o_qbit = ~w_diff[WIDTH];
  assign o_rem  = o_qbit ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed/unsigned multiply and restoring divide, BITS_PER_CYCLE bits per clock.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic           clk,
  input logic           reset_in,
  mult_div_seq_if.slave bus
);
  localparam int ITER = WIDTH / BITS_PER_CYCLE;
  localparam int CW   = cnt_width(ITER);

  generate
    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bpc
      $error("BITS_PER_CYCLE must divide WIDTH");
    end
  endgenerate

  state_e               r_state, w_state_nxt;
  op_e                  r_op, w_start_op;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mb;
  logic                 r_neg_res, r_neg_rem;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_mult_stop, r_div_stop, r_div_zero;
  logic                 w_start, w_zero, w_last;
  logic [WIDTH-1:0]     w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0]   w_mul_acc;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quot, w_rmd;
  logic [BITS_PER_CYCLE:0][WIDTH-1:0] w_rem, w_quo;

  assign w_a_mag = (bus.op_signed && bus.a_in[WIDTH-1]) ? -bus.a_in : bus.a_in;
  assign w_b_mag = (bus.op_signed && bus.b_in[WIDTH-1]) ? -bus.b_in : bus.b_in;
  assign w_last  = (r_cnt == CW'(ITER - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_start_op  = OP_MULT;
    w_zero      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.mult_init) begin
          w_start     = 1'b1;
          w_state_nxt = CALC;
        end else if (bus.div_init) begin
          if (bus.b_in == '0) begin
            w_zero = 1'b1;
          end else begin
            w_start     = 1'b1;
            w_start_op  = OP_DIV;
            w_state_nxt = CALC;
          end
        end
      end
      CALC:    if (w_last) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift-add multiply: acc = {partial product, remaining multiplier bits}.
  always_comb begin
    w_mul_acc = r_acc;
    w_sum     = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      w_sum     = {1'b0, w_mul_acc[2*WIDTH-1:WIDTH]} + (w_mul_acc[0] ? {1'b0, r_mb} : '0);
      w_mul_acc = {w_sum, w_mul_acc[WIDTH-1:1]};
    end
  end

  assign w_rem[0] = r_acc[2*WIDTH-1:WIDTH];
  assign w_quo[0] = r_acc[WIDTH-1:0];

  generate
    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_div
      logic w_qbit;
      div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (w_rem[g]),
        .i_div  (r_mb),
        .i_bit  (w_quo[g][WIDTH-1]),
        .o_rem  (w_rem[g+1]),
        .o_qbit (w_qbit)
      );
      assign w_quo[g+1] = {w_quo[g][WIDTH-2:0], w_qbit};
    end
  endgenerate

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quot = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rmd  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      r_state     <= IDLE;
      r_op        <= OP_MULT;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mb        <= '0;
      r_neg_res   <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_mult_stop <= 1'b0;
      r_div_stop  <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mult_stop <= 1'b0;
      r_div_stop  <= 1'b0;
      r_div_zero  <= w_zero;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_op      <= w_start_op;
            r_cnt     <= '0;
            r_acc     <= {{WIDTH{1'b0}}, (w_start_op == OP_MULT) ? w_b_mag : w_a_mag};
            r_mb      <= (w_start_op == OP_MULT) ? w_a_mag : w_b_mag;
            r_neg_res <= bus.op_signed & (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
            r_neg_rem <= bus.op_signed & bus.a_in[WIDTH-1];
          end
        end
        CALC: begin
          r_acc <= (r_op == OP_MULT) ? w_mul_acc
                                     : {w_rem[BITS_PER_CYCLE], w_quo[BITS_PER_CYCLE]};
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          if (r_op == OP_MULT) begin
            {r_hi, r_lo} <= w_prod;
            r_mult_stop  <= 1'b1;
          end else begin
            r_hi       <= w_rmd;
            r_lo       <= w_quot;
            r_div_stop <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_out    = r_hi;
  assign bus.lo_out    = r_lo;
  assign bus.mult_stop = r_mult_stop;
  assign bus.div_stop  = r_div_stop;
  assign bus.div_zero  = r_div_zero;
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq: vector table, random ops vs. an arithmetic model, corner sequences.
module tb_mult_div_seq;
  logic clk = 1'b0;
  logic reset_in;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mult_div_seq_if #(.WIDTH(32)) bus ();
  mult_div_seq_if #(.WIDTH(32)) bus4 ();

  mult_div_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut  (.clk(clk), .reset_in(reset_in), .bus(bus));
  mult_div_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .reset_in(reset_in), .bus(bus4));

  typedef struct {
    bit          is_div;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[7];

  logic [31:0] res_hi, res_lo, res4_hi, res4_lo;
  int          res_lat, res4_lat, res_busy_bad;
  bit          res_ms, res_ds, res_busy_end, res_extra;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference for the four instructions.
  function automatic void ref_model(input bit is_div, input bit sgn, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] hi,
                                    output logic [31:0] lo);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (!is_div) begin
      if (sgn) begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      else begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
    end else begin
      if (sgn) begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      else begin lo = a / b; hi = a % b; end
    end
  endfunction

  task automatic drive(input bit mi, input bit di, input bit sgn, input logic [31:0] a,
                       input logic [31:0] b, input bit use4);
    bus.mult_init = mi; bus.div_init = di; bus.op_signed = sgn; bus.a_in = a; bus.b_in = b;
    if (use4) begin
      bus4.mult_init = mi; bus4.div_init = di; bus4.op_signed = sgn; bus4.a_in = a; bus4.b_in = b;
    end
  endtask

  task automatic run_op(input bit mi, input bit di, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input bit use4);
    bit seen = 1'b0, seen4 = 1'b0;
    res_lat = 0; res4_lat = 0; res_busy_bad = 0; res_extra = 1'b0;
    res_ms = 1'b0; res_ds = 1'b0;
    @(negedge clk);
    drive(mi, di, sgn, a, b, use4);
    @(posedge clk); #1;
    bus.mult_init = 1'b0; bus.div_init = 1'b0;
    bus4.mult_init = 1'b0; bus4.div_init = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (!bus.busy) res_busy_bad++;
      @(posedge clk); #1;
      if (use4 && !seen4 && (bus4.mult_stop || bus4.div_stop)) begin
        seen4 = 1'b1; res4_lat = k; res4_hi = bus4.hi_out; res4_lo = bus4.lo_out;
      end
      if (bus.mult_stop || bus.div_stop) begin
        seen = 1'b1; res_lat = k; res_ms = bus.mult_stop; res_ds = bus.div_stop;
        res_hi = bus.hi_out; res_lo = bus.lo_out;
      end
    end
    res_busy_end = bus.busy;
    if (seen) begin
      @(posedge clk); #1;
      res_extra = bus.mult_stop | bus.div_stop;
    end
  endtask

  task automatic check_result(input string tag, input bit is_div, input logic [31:0] ehi,
                              input logic [31:0] elo, input bit use4);
    check({tag, " latency"}, res_lat, 33);
    check({tag, " hi"}, res_hi, ehi);
    check({tag, " lo"}, res_lo, elo);
    check({tag, " mult_stop"}, res_ms, !is_div);
    check({tag, " div_stop"}, res_ds, is_div);
    check({tag, " busy during op"}, res_busy_bad, 0);
    check({tag, " busy after op"}, res_busy_end, 0);
    check({tag, " stop single pulse"}, res_extra, 0);
    if (use4) begin
      check({tag, " bpc4 latency"}, res4_lat, 9);
      check({tag, " bpc4 hi"}, res4_hi, ehi);
      check({tag, " bpc4 lo"}, res4_lo, elo);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ehi, elo, a, b, pre_hi, pre_lo;
    bit          is_div, sgn;
    int          mc, dc, lat, sc;

    tbl[0] = '{1'b0, 1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[6] = '{1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    reset_in = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    check("reset hi", bus.hi_out, 0);
    check("reset lo", bus.lo_out, 0);
    check("reset busy", bus.busy, 0);
    check("reset stops", {bus.mult_stop, bus.div_stop, bus.div_zero}, 0);
    @(negedge clk);
    reset_in = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(!tbl[i].is_div, tbl[i].is_div, tbl[i].sgn, tbl[i].a, tbl[i].b, 1'b1);
      check_result($sformatf("vec%0d", i), tbl[i].is_div, tbl[i].hi, tbl[i].lo, 1'b1);
    end

    for (int i = 0; i < 24; i++) begin
      is_div = 1'($urandom_range(0, 1));
      sgn    = 1'($urandom_range(0, 1));
      a      = $urandom;
      b      = $urandom;
      if ($urandom_range(0, 2) == 0) b = $urandom_range(1, 20);
      if ($urandom_range(0, 3) == 0) b = -b;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if (b == 0) b = 32'd1;
      ref_model(is_div, sgn, a, b, ehi, elo);
      run_op(!is_div, is_div, sgn, a, b, 1'b1);
      check_result($sformatf("rand%0d", i), is_div, ehi, elo, 1'b1);
    end

    // Divide by zero after preloading hi/lo.
    run_op(1'b1, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0);
    pre_hi = bus.hi_out; pre_lo = bus.lo_out;
    check("dz preload lo", pre_lo, 32'hFFFF_FFEB);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'd5, 32'd0, 1'b0);
    @(posedge clk); #1;
    bus.div_init = 1'b0;
    check("dz div_zero pulse", bus.div_zero, 1);
    check("dz busy", bus.busy, 0);
    check("dz no div_stop", bus.div_stop, 0);
    @(posedge clk); #1;
    check("dz div_zero drop", bus.div_zero, 0);
    check("dz no div_stop later", bus.div_stop, 0);
    check("dz busy later", bus.busy, 0);
    check("dz hi hold", bus.hi_out, pre_hi);
    check("dz lo hold", bus.lo_out, pre_lo);

    // Init while busy, plus operand change during CALC.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'd5, 32'd6, 1'b0);
    @(posedge clk); #1;
    bus.mult_init = 1'b0;
    mc = 0; dc = 0; lat = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 10) begin bus.div_init = 1'b1; bus.a_in = 32'd100; bus.b_in = 32'd3; end
      if (k == 11) bus.div_init = 1'b0;
      @(posedge clk); #1;
      if (bus.mult_stop) begin
        mc++;
        if (lat == 0) begin lat = k; ehi = bus.hi_out; elo = bus.lo_out; end
      end
      if (bus.div_stop || bus.div_zero) dc++;
    end
    check("busy-init mult_stop count", mc, 1);
    check("busy-init div pulses", dc, 0);
    check("busy-init latency", lat, 33);
    check("busy-init hi", ehi, 0);
    check("busy-init lo", elo, 30);

    // Both inits together: multiply wins.
    run_op(1'b1, 1'b1, 1'b0, 32'd9, 32'd4, 1'b0);
    check_result("simul", 1'b0, 32'd0, 32'd36, 1'b0);

    // Asynchronous reset in the middle of CALC.
    run_op(1'b1, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
    @(posedge clk); #1;
    bus.mult_init = 1'b0;
    repeat (15) @(posedge clk);
    #1 reset_in = 1'b1;
    #1;
    check("rst-mid hi", bus.hi_out, 0);
    check("rst-mid lo", bus.lo_out, 0);
    check("rst-mid busy", bus.busy, 0);
    check("rst-mid stops", {bus.mult_stop, bus.div_stop, bus.div_zero}, 0);
    @(negedge clk); @(negedge clk);
    reset_in = 1'b0;
    sc = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.mult_stop || bus.div_stop || bus.div_zero) sc++;
    end
    check("rst-mid no stop after release", sc, 0);
    run_op(1'b1, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1);
    check_result("rst-mid fresh", 1'b0, 32'd0, 32'hFFFE_0001, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
Parametrised iterative multiply/divide unit that serves the MULT/MULTU/DIV/DIVU path of the multicycle CPU. It is started by the control unit through `mult_init`/`div_init`. It reports completion or divide-by-zero through `mult_stop`/`div_stop`/`div_zero`. Results go to the HI/LO datapath registers via `hi_out`/`lo_out`. It generalises the fixed 32-bit signed-only unit with configurable width, bits-per-cycle throughput and a signed/unsigned mode.

Parameters:
- WIDTH, 32, operand width; products and results are split into HI/LO of WIDTH bits each.
- BITS_PER_CYCLE, 1, iteration bits retired per clock; must divide WIDTH (elaboration error otherwise).
- ITER (local), WIDTH/BITS_PER_CYCLE, number of CALC cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- mult_init  in  1  start multiply; sampled in IDLE only.
- div_init  in  1  start divide; sampled in IDLE only.
- op_signed  in  1  1 = two's-complement operands (MULT/DIV), 0 = unsigned (MULTU/DIVU); latched with init.
- a_in  in  WIDTH  multiplicand / dividend.
- b_in  in  WIDTH  multiplier / divisor.
- hi_out  out  WIDTH  product upper half / remainder.
- lo_out  out  WIDTH  product lower half / quotient.
- mult_stop  out  1  one-cycle pulse: multiply result valid.
- div_stop  out  1  one-cycle pulse: divide result valid.
- div_zero  out  1  one-cycle pulse: divisor was zero, operation aborted.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; hi_out, lo_out, mult_stop, div_stop, div_zero, busy = 0; internal accumulators cleared. A reset mid-operation produces no stop pulse.
- FSM states: IDLE, CALC, FIX.
- IDLE → CALC: at edge N when mult_init or div_init is high. a_in, b_in, op_signed and the op type are latched. If both inits are high, multiply wins.
- Signed mode converts operands to magnitudes at latch time and records the result signs.
- IDLE → IDLE on div_init with b_in==0: div_zero high for the cycle after edge N. hi_out/lo_out hold their values; no div_stop.
- CALC: iteration counter runs 0..ITER-1, one count per edge.
  - Multiply: shift-add, BITS_PER_CYCLE partial products per cycle, 2·WIDTH accumulator.
  - Divide: restoring division, BITS_PER_CYCLE chained steps per cycle.
  - Last count → FIX.
- FIX (1 cycle): apply signs.
  - Product negated if operand signs differ.
  - Quotient negated if signs differ; remainder takes the sign of the dividend.
  - At edge N+ITER+1: hi_out/lo_out are updated, the relevant stop pulses high for exactly one cycle, and state returns to IDLE.
- Latency: N+ITER+1 edges from init to result; 33 for the defaults.
- hi_out/lo_out hold until the next completed operation.
- Init while busy is ignored; no queueing.
- A new init is accepted in the same cycle a stop pulse is high.
- Operands are ignored after the latch; changing a_in/b_in during CALC has no effect.
- Overflow case: signed most-negative / -1 gives lo_out = 2^(WIDTH-1) bit pattern (wraps), hi_out = 0, no flag.
- All arithmetic wraps modulo 2^WIDTH per half; no overflow output.

Decomposition:
- Package mult_div_pkg:
  - FSM state enum (IDLE, CALC, FIX).
  - Op-type encoding (OP_MULT, OP_DIV).
  - Helper function for the ITER count width, clog2(ITER).
- Sub-module div_step: one combinational restoring-division step (remainder, divisor, next dividend bit → new remainder, quotient bit). It is instantiated BITS_PER_CYCLE times in a generate chain.

Test Plan:
- Signed multiply, defaults: op_signed=1, a=7, b=0xFFFFFFFD (-3), mult_init pulse → after 33 edges mult_stop pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high throughout.
- Unsigned multiply: op_signed=0, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Repeat with BITS_PER_CYCLE=4 → same result after 9 edges.
- Signed divide:
  - a=0xFFFFFFF9 (-7), b=2 → div_stop after 33 edges; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: preload hi/lo via a multiply, then div_init with b=0 → div_zero high exactly one cycle after the init edge; no div_stop; hi/lo unchanged; busy stays 0.
- Init while busy and simultaneous init: div_init at cycle 10 of a multiply is ignored, with a single mult_stop and a multiply result. Both inits high in IDLE → multiply performed, only mult_stop pulses.
- Reset mid-operation: reset_in high at CALC cycle 15 → all outputs 0 immediately (asynchronous). After release no stop pulses, and a fresh mult_init completes normally.
